matrix_stream_loader: RTL and testbench

Parametrised ASCII matrix loader that sits between the UART byte receiver and the matrix-storage write mux. It parses decimal tokens from a byte stream and performs one of three tasks: matrix-ID entry, dimension-only entry, or full load of 1..MAX_GEN matrices. A full load is either user-typed (signed elements, zero pre-fill) or LFSR-generated. Compared with the previous loader it generalises dimension, element range, data width and generate count, and adds:
- signed elements;
- empty-token skipping;
- overflow-safe accumulation;
- an entry timeout that terminates entry.

---
 rtl/matrix_stream_loader.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_matrix_stream_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader
// Parses decimal tokens from a UART byte stream. Depending on task_mode it
// captures a matrix ID, a pair of dimensions, or loads 1..MAX_GEN matrices
// (typed with zero pre-fill, or LFSR-generated) through a write port.
module matrix_stream_loader #(
    parameter int          MAX_DIM   = 5,
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 8,
    parameter int          ELEM_MIN  = 0,
    parameter int          ELEM_MAX  = 9,
    parameter int          MAX_GEN   = 2,
    parameter int          TIMEOUT   = 50_000_000,
    parameter logic [31:0] LFSR_SEED = 32'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        task_mode,
    input  logic              gen_mode,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              addr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] dim_m,
    output logic [DATA_W-1:0] dim_n,
    output logic              dims_valid,
    output logic [1:0]        mat_idx,
    output logic [DATA_W-1:0] id_val,
    output logic              id_valid,
    output logic              done,
    output logic              error
);

    localparam int CNT_W  = $clog2(MAX_DIM * MAX_DIM + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_RX_M     = 3'd0;
    localparam logic [2:0] ST_RX_N     = 3'd1;
    localparam logic [2:0] ST_RX_CNT   = 3'd2;
    localparam logic [2:0] ST_REQ_ADDR = 3'd3;
    localparam logic [2:0] ST_CLEAR    = 3'd4;
    localparam logic [2:0] ST_ENTRY    = 3'd5;
    localparam logic [2:0] ST_GEN      = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    localparam logic [DATA_W-1:0]        MAX_POS   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] EMIN      = DATA_W'(ELEM_MIN);
    localparam logic signed [DATA_W-1:0] EMAX      = DATA_W'(ELEM_MAX);
    localparam logic [DATA_W-1:0]        DIM_LIMIT = DATA_W'(MAX_DIM);
    localparam logic [DATA_W-1:0]        GEN_LIMIT = DATA_W'(MAX_GEN);
    localparam logic [31:0]              RANGE_U   = 32'(ELEM_MAX - ELEM_MIN + 1);
    localparam logic                     NEG_OK    = (ELEM_MIN < 0);

    logic [2:0]        state_reg;
    logic [DATA_W-1:0] acc_reg;
    logic              ovf_reg;
    logic              neg_reg;
    logic              digits_reg;
    logic [CNT_W-1:0]  offset_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [1:0]        gen_total_reg;
    logic [IDLE_W-1:0] idle_reg;
    logic [31:0]       lfsr_reg;

    logic              is_digit, is_eol, is_delim, is_minus;
    logic [DATA_W+3:0] acc_wide;
    logic [DATA_W-1:0] acc_sat;
    logic              ovf_now;
    logic [DATA_W-1:0] tok_val;
    logic              dim_ok, cnt_ok, elem_ok, minus_ok;
    logic [31:0]       gen_mod;
    logic [DATA_W-1:0] gen_val;
    logic              last_elem, more_mats, mode3_hold;

    // Byte classification, saturating accumulator and token range checks
    always_comb begin
        is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_delim = is_eol || (rx_data == 8'h20);
        is_minus = (rx_data == 8'h2D);

        acc_wide = ({4'd0, acc_reg} << 3) + ({4'd0, acc_reg} << 1)
                 + {{DATA_W{1'b0}}, rx_data[3:0]};
        if (acc_wide > {4'd0, MAX_POS}) begin
            acc_sat = MAX_POS;
            ovf_now = 1'b1;
        end else begin
            acc_sat = acc_wide[DATA_W-1:0];
            ovf_now = 1'b0;
        end

        tok_val  = neg_reg ? (~acc_reg + 1'b1) : acc_reg;
        dim_ok   = !ovf_reg && !neg_reg && (acc_reg != '0) && (acc_reg <= DIM_LIMIT);
        cnt_ok   = !ovf_reg && !neg_reg && (acc_reg != '0) && (acc_reg <= GEN_LIMIT);
        elem_ok  = !ovf_reg && ($signed(tok_val) >= EMIN) && ($signed(tok_val) <= EMAX);
        minus_ok = NEG_OK && (state_reg == ST_ENTRY) && !digits_reg && !neg_reg;

        gen_mod  = lfsr_reg % RANGE_U;
        gen_val  = DATA_W'(gen_mod) + EMIN;

        last_elem  = ((offset_reg + CNT_W'(1)) == count_reg);
        more_mats  = (({1'b0, mat_idx} + 3'd1) < {1'b0, gen_total_reg});
        mode3_hold = (state_reg == ST_RX_M) && (task_mode == 2'd3);
    end

    // Free-running LFSR, advances regardless of en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[30:0], lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1]};
        end
    end

    // Main control: token parsing, task sequencing and write generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RX_M;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            neg_reg       <= 1'b0;
            digits_reg    <= 1'b0;
            offset_reg    <= '0;
            count_reg     <= '0;
            base_reg      <= '0;
            gen_total_reg <= '0;
            idle_reg      <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            dim_m         <= '0;
            dim_n         <= '0;
            dims_valid    <= 1'b0;
            mat_idx       <= '0;
            id_val        <= '0;
            id_valid      <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else if (!en) begin
            // Dimensions and ID survive a disable; everything else restarts
            state_reg  <= ST_RX_M;
            acc_reg    <= '0;
            ovf_reg    <= 1'b0;
            neg_reg    <= 1'b0;
            digits_reg <= 1'b0;
            offset_reg <= '0;
            idle_reg   <= '0;
            mat_idx    <= '0;
            error      <= 1'b0;
            done       <= 1'b0;
            wr_en      <= 1'b0;
            id_valid   <= 1'b0;
            dims_valid <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            id_valid <= 1'b0;
            if ((state_reg != ST_ENTRY) || rx_valid) begin
                idle_reg <= '0;
            end

            case (state_reg)
                ST_REQ_ADDR: begin
                    // The offset-0 write is issued with the handshake so the
                    // first write lands one cycle after addr_ready.
                    if (addr_ready) begin
                        dims_valid <= 1'b0;
                        base_reg   <= base_addr;
                        wr_en      <= 1'b1;
                        wr_addr    <= base_addr;
                        wr_data    <= gen_mode ? gen_val : '0;
                        offset_reg <= CNT_W'(1);
                        state_reg  <= gen_mode ? ST_GEN : ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    if (offset_reg < count_reg) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= base_reg + ADDR_W'(offset_reg);
                        wr_data    <= '0;
                        offset_reg <= offset_reg + CNT_W'(1);
                    end else begin
                        offset_reg <= '0;
                        state_reg  <= ST_ENTRY;
                    end
                end

                ST_GEN: begin
                    if (offset_reg < count_reg) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= base_reg + ADDR_W'(offset_reg);
                        wr_data    <= gen_val;
                        offset_reg <= offset_reg + CNT_W'(1);
                    end else begin
                        offset_reg <= '0;
                        mat_idx    <= mat_idx + 2'd1;
                        if (more_mats) begin
                            dims_valid <= 1'b1;
                            state_reg  <= ST_REQ_ADDR;
                        end else begin
                            done      <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                end

                default: begin
                    // Byte-consuming states: RX_M, RX_N, RX_CNT, ENTRY
                    if ((state_reg == ST_ENTRY) && !rx_valid) begin
                        if (idle_reg == IDLE_W'(TIMEOUT - 1)) begin
                            done      <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            idle_reg <= idle_reg + 1'b1;
                        end
                    end

                    if (rx_valid && !mode3_hold) begin
                        if (is_digit) begin
                            acc_reg    <= acc_sat;
                            ovf_reg    <= ovf_reg | ovf_now;
                            digits_reg <= 1'b1;
                            if (state_reg == ST_RX_M) begin
                                error <= 1'b0;
                            end
                        end else if (is_minus && minus_ok) begin
                            neg_reg <= 1'b1;
                        end else if (is_delim) begin
                            acc_reg    <= '0;
                            ovf_reg    <= 1'b0;
                            neg_reg    <= 1'b0;
                            digits_reg <= 1'b0;
                            if (!digits_reg) begin
                                // Empty token: only an end-of-line in ENTRY matters
                                if ((state_reg == ST_ENTRY) && is_eol) begin
                                    done      <= 1'b1;
                                    state_reg <= ST_DONE;
                                end
                            end else if (state_reg == ST_RX_M) begin
                                if (task_mode == 2'd2) begin
                                    id_val    <= acc_reg;
                                    id_valid  <= 1'b1;
                                    done      <= 1'b1;
                                    state_reg <= ST_DONE;
                                end else if (dim_ok) begin
                                    dim_m     <= acc_reg;
                                    state_reg <= ST_RX_N;
                                end else begin
                                    error <= 1'b1;
                                end
                            end else if (state_reg == ST_RX_N) begin
                                if (!dim_ok) begin
                                    error     <= 1'b1;
                                    state_reg <= ST_RX_M;
                                end else begin
                                    dim_n     <= acc_reg;
                                    count_reg <= CNT_W'(dim_m[CNT_W-1:0] * acc_reg[CNT_W-1:0]);
                                    if (task_mode == 2'd1) begin
                                        done      <= 1'b1;
                                        state_reg <= ST_DONE;
                                    end else if (gen_mode) begin
                                        state_reg <= ST_RX_CNT;
                                    end else begin
                                        gen_total_reg <= 2'd1;
                                        mat_idx       <= '0;
                                        dims_valid    <= 1'b1;
                                        state_reg     <= ST_REQ_ADDR;
                                    end
                                end
                            end else if (state_reg == ST_RX_CNT) begin
                                if (cnt_ok) begin
                                    gen_total_reg <= 2'(acc_reg);
                                    mat_idx       <= '0;
                                    dims_valid    <= 1'b1;
                                    state_reg     <= ST_REQ_ADDR;
                                end else begin
                                    error     <= 1'b1;
                                    state_reg <= ST_RX_M;
                                end
                            end else begin
                                if (elem_ok) begin
                                    wr_en      <= 1'b1;
                                    wr_addr    <= base_reg + ADDR_W'(offset_reg);
                                    wr_data    <= tok_val;
                                    offset_reg <= offset_reg + CNT_W'(1);
                                    if (last_elem || is_eol) begin
                                        done      <= 1'b1;
                                        state_reg <= ST_DONE;
                                    end
                                end else begin
                                    error     <= 1'b1;
                                    state_reg <= ST_RX_M;
                                end
                            end
                        end else begin
                            // Illegal byte (or misplaced minus)
                            error      <= 1'b1;
                            acc_reg    <= '0;
                            ovf_reg    <= 1'b0;
                            neg_reg    <= 1'b0;
                            digits_reg <= 1'b0;
                            state_reg  <= ST_RX_M;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Testbench for matrix_stream_loader: table of ID/dimension vectors plus
// hand-written load, generate, error, timeout and disable sequences.
module tb_matrix_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  task_mode = 2'd0;
    logic        gen_mode = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [7:0]  base_addr = 8'd0;
    logic        addr_ready = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] dim_m, dim_n, id_val;
    logic        dims_valid, id_valid, done, error;
    logic [1:0]  mat_idx;

    int n_cmp = 0;
    int n_err = 0;

    matrix_stream_loader #(
        .MAX_DIM(5), .DATA_W(32), .ADDR_W(8), .ELEM_MIN(-9), .ELEM_MAX(9),
        .MAX_GEN(2), .TIMEOUT(20), .LFSR_SEED(32'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .task_mode(task_mode),
        .gen_mode(gen_mode), .rx_data(rx_data), .rx_valid(rx_valid),
        .base_addr(base_addr), .addr_ready(addr_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .dim_m(dim_m), .dim_n(dim_n),
        .dims_valid(dims_valid), .mat_idx(mat_idx), .id_val(id_val),
        .id_valid(id_valid), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Write and ID-pulse monitor, sampled on the falling edge
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          id_cnt = 0;
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (id_valid === 1'b1) id_cnt++;
    end

    typedef struct {
        logic [1:0]  mode;
        string       bytes;
        logic        exp_done;
        logic        exp_err;
        logic [31:0] exp_m;
        logic [31:0] exp_n;
        int          exp_ids;
        logic [31:0] exp_id;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic sv(input int i, input logic [1:0] m, input string s, input logic d,
                      input logic e, input logic [31:0] dm, input logic [31:0] dn,
                      input int ids, input logic [31:0] id);
        vecs[i].mode = m; vecs[i].bytes = s; vecs[i].exp_done = d; vecs[i].exp_err = e;
        vecs[i].exp_m = dm; vecs[i].exp_n = dn; vecs[i].exp_ids = ids; vecs[i].exp_id = id;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic restart();
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
    endtask

    task automatic handshake(input logic [7:0] a);
        @(negedge clk);
        base_addr = a;
        addr_ready = 1'b1;
        @(negedge clk);
        addr_ready = 1'b0;
    endtask

    // Bounded wait: which = 0 waits for dims_valid, 1 waits for done
    task automatic wait_for(input int which, input int maxc, input string name);
        int c = 0;
        while ((((which == 0) ? dims_valid : done) !== 1'b1) && (c < maxc)) begin
            @(negedge clk);
            c++;
        end
        check(name, {31'd0, (which == 0) ? dims_valid : done}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ids0;
        int last_wr;
        int done_c;

        sv(0,  2'd2, "17 ",          1, 0, 0, 0, 1, 17);
        sv(1,  2'd1, "3 4 ",         1, 0, 3, 4, 0, 17);
        sv(2,  2'd1, "7 ",           0, 1, 3, 4, 0, 17);
        sv(3,  2'd1, "7 2",          0, 0, 3, 4, 0, 17);
        sv(4,  2'd1, "99999999999 ", 0, 1, 3, 4, 0, 17);
        sv(5,  2'd2, "  0042\015",   1, 0, 3, 4, 1, 42);
        sv(6,  2'd1, "5 1\n",        1, 0, 5, 1, 0, 42);
        sv(7,  2'd1, "0 ",           0, 1, 5, 1, 0, 42);
        sv(8,  2'd1, "2 x",          0, 1, 2, 1, 0, 42);
        sv(9,  2'd1, "-3 ",          0, 0, 3, 1, 0, 42);
        sv(10, 2'd2, "99999999999 ", 1, 0, 3, 1, 1, 32'h7FFFFFFF);
        sv(11, 2'd3, "3 4 ",         0, 0, 3, 1, 0, 32'h7FFFFFFF);
        sv(12, 2'd1, "6 ",           0, 1, 3, 1, 0, 32'h7FFFFFFF);
        sv(13, 2'd1, "5 5\n \n",     1, 0, 5, 5, 0, 32'h7FFFFFFF);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_en", {31'd0, wr_en}, 0);
        check("rst_dims_valid", {31'd0, dims_valid}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_error", {31'd0, error}, 0);
        check("rst_id_valid", {31'd0, id_valid}, 0);
        check("rst_dim_m", dim_m, 0);
        check("rst_id_val", id_val, 0);
        check("rst_mat_idx", {30'd0, mat_idx}, 0);
        rst_n = 1'b1;

        // Table-driven ID / dimension vectors
        for (int i = 0; i < 14; i++) begin
            task_mode = vecs[i].mode;
            gen_mode = 1'b0;
            restart();
            ids0 = id_cnt;
            send_str(vecs[i].bytes);
            repeat (2) @(negedge clk);
            $display("vec %0d mode %0d", i, vecs[i].mode);
            check($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
            check($sformatf("v%0d_error", i), {31'd0, error}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_dim_m", i), dim_m, vecs[i].exp_m);
            check($sformatf("v%0d_dim_n", i), dim_n, vecs[i].exp_n);
            check($sformatf("v%0d_id_pulses", i), 32'(id_cnt - ids0), 32'(vecs[i].exp_ids));
            check($sformatf("v%0d_id_val", i), id_val, vecs[i].exp_id);
        end

        // Typed load: 2x2 at 0x10, elements 5 and -3
        task_mode = 2'd0; gen_mode = 1'b0;
        restart();
        base = wa_q.size();
        send_str("2 2 ");
        wait_for(0, 10, "typed_dims_valid");
        handshake(8'h10);
        check("typed_dims_drop", {31'd0, dims_valid}, 0);
        repeat (6) @(negedge clk);
        send_str("5 -3\015");
        repeat (2) @(negedge clk);
        check("typed_done", {31'd0, done}, 1);
        check("typed_error", {31'd0, error}, 0);
        check("typed_nwrites", 32'(wa_q.size() - base), 6);
        if (wa_q.size() - base == 6) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("typed_clr_addr%0d", k), {24'd0, wa_q[base+k]}, 32'h10 + 32'(k));
                check($sformatf("typed_clr_data%0d", k), wd_q[base+k], 0);
            end
            check("typed_e0_addr", {24'd0, wa_q[base+4]}, 32'h10);
            check("typed_e0_data", wd_q[base+4], 32'd5);
            check("typed_e1_addr", {24'd0, wa_q[base+5]}, 32'h11);
            check("typed_e1_data", wd_q[base+5], 32'hFFFFFFFD);
        end

        // Generated load: 2x3, two matrices
        task_mode = 2'd0; gen_mode = 1'b1;
        restart();
        base = wa_q.size();
        send_str("2 3 2 ");
        wait_for(0, 10, "gen_dims_valid0");
        check("gen_mat_idx0", {30'd0, mat_idx}, 0);
        handshake(8'h20);
        wait_for(0, 20, "gen_dims_valid1");
        check("gen_mat_idx1", {30'd0, mat_idx}, 1);
        handshake(8'h40);
        wait_for(1, 20, "gen_done");
        repeat (2) @(negedge clk);
        check("gen_nwrites", 32'(wa_q.size() - base), 12);
        if (wa_q.size() - base == 12) begin
            for (int k = 0; k < 12; k++) begin
                check($sformatf("gen_addr%0d", k), {24'd0, wa_q[base+k]},
                      (k < 6) ? (32'h20 + 32'(k)) : (32'h40 + 32'(k - 6)));
                check($sformatf("gen_range%0d", k),
                      {31'd0, ($signed(wd_q[base+k]) >= -9) && ($signed(wd_q[base+k]) <= 9)}, 1);
            end
        end
        gen_mode = 1'b0;

        // Illegal byte in ENTRY returns to RX_M with error
        task_mode = 2'd0;
        restart();
        base = wa_q.size();
        send_str("1 1 ");
        wait_for(0, 10, "err_dims_valid");
        handshake(8'h00);
        repeat (3) @(negedge clk);
        send_str("a");
        repeat (2) @(negedge clk);
        check("err_entry_error", {31'd0, error}, 1);
        check("err_entry_done", {31'd0, done}, 0);
        check("err_entry_nwrites", 32'(wa_q.size() - base), 1);
        task_mode = 2'd1;
        send_str("4 ");
        repeat (2) @(negedge clk);
        check("err_back_in_rxm_dim_m", dim_m, 4);
        check("err_cleared", {31'd0, error}, 0);

        // Out-of-range element in ENTRY
        task_mode = 2'd0;
        restart();
        send_str("1 1 ");
        wait_for(0, 10, "oor_dims_valid");
        handshake(8'h00);
        repeat (3) @(negedge clk);
        send_str("12 ");
        repeat (2) @(negedge clk);
        check("oor_error", {31'd0, error}, 1);
        check("oor_done", {31'd0, done}, 0);

        // count-th write ends ENTRY
        restart();
        base = wa_q.size();
        send_str("1 1 ");
        wait_for(0, 10, "last_dims_valid");
        handshake(8'h50);
        repeat (3) @(negedge clk);
        send_str("8 ");
        repeat (2) @(negedge clk);
        check("last_done", {31'd0, done}, 1);
        check("last_nwrites", 32'(wa_q.size() - base), 2);
        if (wa_q.size() - base == 2) begin
            check("last_addr", {24'd0, wa_q[base+1]}, 32'h50);
            check("last_data", wd_q[base+1], 8);
        end

        // Entry timeout: 20 idle cycles in ENTRY
        restart();
        send_str("1 2 ");
        wait_for(0, 10, "to_dims_valid");
        handshake(8'h00);
        last_wr = -100;
        done_c = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wr_en === 1'b1) last_wr = c;
            if ((done === 1'b1) && (done_c < 0)) done_c = c;
        end
        check("timeout_cycles", 32'(done_c - last_wr), 21);

        // en low clears error; en low mid-ENTRY returns to RX_M
        task_mode = 2'd1;
        restart();
        send_str("9 ");
        repeat (2) @(negedge clk);
        check("en_pre_error", {31'd0, error}, 1);
        restart();
        check("en_error_cleared", {31'd0, error}, 0);
        task_mode = 2'd0;
        send_str("1 2 ");
        wait_for(0, 10, "en_dims_valid");
        handshake(8'h30);
        repeat (3) @(negedge clk);
        send_str("4 ");
        @(negedge clk);
        check("en_mid_entry_done", {31'd0, done}, 0);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        check("en_after_done", {31'd0, done}, 0);
        check("en_after_error", {31'd0, error}, 0);
        task_mode = 2'd1;
        send_str("4 3 ");
        repeat (2) @(negedge clk);
        check("en_rxm_dim_m", dim_m, 4);
        check("en_rxm_dim_n", dim_n, 3);
        check("en_rxm_done", {31'd0, done}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
